game_clock_ascii: RTL and testbench

Game-time engine for the basketball scoreboard. It counts down each period in MM:SS, tracks the period number, and handles start/stop and period-advance commands. It presents every digit as a registered ASCII byte that drives the LCD driver's minute, second and period character inputs directly. Counting is done in BCD digits, so no binary-to-decimal conversion is needed downstream.

---
 rtl/game_clock_ascii.sv | 210 +++++++++++++++++++++
 tb/tb_game_clock_ascii.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_clock_ascii.sv
// game_clock_ascii
//   Basketball game-clock engine. It counts each period down in BCD MM:SS,
//   tracks the period number and runs a small run/pause/expiry FSM. Every
//   digit is presented as an ASCII byte, taken straight from the digit
//   registers, so it can feed an LCD character driver directly.
//
// Parameters
//   TICK_DIV     clk cycles per game second (>= 2)
//   PERIOD_MIN   period length in minutes (1..99)
//   NUM_PERIODS  number of periods (1..9)
//   BUZZ_CYCLES  horn length in clk cycles (buzzer build only)
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start_stop           1-cycle pulse: IDLE->RUN, RUN<->PAUSE
//   next_period          1-cycle pulse: leave EXPIRED (next period or game over)
//   ascii_1_min/0_min    minutes tens/ones, ASCII
//   ascii_1_sec/0_sec    seconds tens/ones, ASCII
//   ascii_0_period       period number, ASCII
//   running              high while in RUN
//   period_end           1-cycle pulse when the clock reaches 00:00
//   game_over            high in GAME_OVER
//   buzzer               period-end horn
//
// Build option
//   GAME_CLOCK_BUZZER_EN  when defined, buzzer is held high for BUZZ_CYCLES
//                         cycles starting with period_end; otherwise tied 0.

module game_clock_ascii #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int PERIOD_MIN  = 10,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       next_period,
  output logic [7:0] ascii_1_min,
  output logic [7:0] ascii_0_min,
  output logic [7:0] ascii_1_sec,
  output logic [7:0] ascii_0_sec,
  output logic [7:0] ascii_0_period,
  output logic       running,
  output logic       period_end,
  output logic       game_over,
  output logic       buzzer
);

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("TICK_DIV must be >= 2");
  end
  if (PERIOD_MIN < 1 || PERIOD_MIN > 99) begin : g_bad_pmin
    $error("PERIOD_MIN must be 1..99");
  end
  if (NUM_PERIODS < 1 || NUM_PERIODS > 9) begin : g_bad_nper
    $error("NUM_PERIODS must be 1..9");
  end
  if (BUZZ_CYCLES < 1) begin : g_bad_buzz
    $error("BUZZ_CYCLES must be >= 1");
  end

  localparam int              PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]      M1_INIT = 4'(PERIOD_MIN / 10);
  localparam logic [3:0]      M0_INIT = 4'(PERIOD_MIN % 10);
  localparam logic [3:0]      P_LAST  = 4'(NUM_PERIODS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    EXPIRED   = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       m1, m0, s1, s0;
  logic [3:0]       period;
  logic [PRE_W-1:0] pre;

  logic tick, last_sec, expire, reload;
  logic running_nx, game_over_nx, period_end_nx;

  assign tick     = (state == RUN) && (pre == PRE_MAX);
  // 00:01 is the only value whose decrement lands on 00:00.
  assign last_sec = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd1);
  assign expire   = tick && last_sec;
  assign reload   = (state == EXPIRED) && next_period && (period < P_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state. Expiry outranks start_stop in RUN, and next_period
  // outranks start_stop in EXPIRED (start_stop is simply not looked at there).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start_stop) state_nx = RUN;
      RUN: begin
        if (expire)          state_nx = EXPIRED;
        else if (start_stop) state_nx = PAUSE;
      end
      PAUSE:     if (start_stop) state_nx = RUN;
      EXPIRED:   if (next_period) state_nx = (period < P_LAST) ? IDLE : GAME_OVER;
      GAME_OVER: state_nx = GAME_OVER;
      default:   state_nx = IDLE;
    endcase
  end

  // FSM: outputs, computed from the next state so the flops below line up
  // with the state they describe.
  always_comb begin
    running_nx    = (state_nx == RUN);
    game_over_nx  = (state_nx == GAME_OVER);
    period_end_nx = expire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running    <= 1'b0;
      game_over  <= 1'b0;
      period_end <= 1'b0;
    end else begin
      running    <= running_nx;
      game_over  <= game_over_nx;
      period_end <= period_end_nx;
    end
  end

  // Datapath: prescaler, BCD countdown, period counter. The prescaler only
  // advances in RUN, so a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (rst) begin
      m1     <= M1_INIT;
      m0     <= M0_INIT;
      s1     <= 4'd0;
      s0     <= 4'd0;
      period <= 4'd1;
      pre    <= '0;
    end else if (reload) begin
      m1     <= M1_INIT;
      m0     <= M0_INIT;
      s1     <= 4'd0;
      s0     <= 4'd0;
      period <= period + 4'd1;
      pre    <= '0;
    end else if (state == RUN) begin
      if (tick) begin
        pre <= '0;
        if (s0 != 4'd0) begin
          s0 <= s0 - 4'd1;
        end else if (s1 != 4'd0) begin
          s0 <= 4'd9;
          s1 <= s1 - 4'd1;
        end else begin
          // In RUN the clock is never 00:00, so a minute is available here.
          s0 <= 4'd9;
          s1 <= 4'd5;
          if (m0 != 4'd0) begin
            m0 <= m0 - 4'd1;
          end else begin
            m0 <= 4'd9;
            m1 <= m1 - 4'd1;
          end
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  assign ascii_1_min    = {4'h3, m1};
  assign ascii_0_min    = {4'h3, m0};
  assign ascii_1_sec    = {4'h3, s1};
  assign ascii_0_sec    = {4'h3, s0};
  assign ascii_0_period = {4'h3, period};

`ifdef GAME_CLOCK_BUZZER_EN
  localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  logic [BUZZ_W-1:0] buzz_cnt;
  logic              buzz_q;

  // buzz_cnt holds the cycles remaining after the current one; a new
  // period end restarts the horn. next_period has no say here.
  always_ff @(posedge clk) begin
    if (rst) begin
      buzz_q   <= 1'b0;
      buzz_cnt <= '0;
    end else if (period_end_nx) begin
      buzz_q   <= 1'b1;
      buzz_cnt <= BUZZ_W'(BUZZ_CYCLES - 1);
    end else if (buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - 1'b1;
    end else begin
      buzz_q   <= 1'b0;
    end
  end

  assign buzzer = buzz_q;
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_game_clock_ascii.sv
// Bench for game_clock_ascii with TICK_DIV=4, PERIOD_MIN=1, NUM_PERIODS=2,
// BUZZ_CYCLES=3. A seconds-remaining model is checked against every output
// on each falling edge; directed steps add hand-computed literal checks.

module tb_game_clock_ascii;

  localparam int TICK_DIV    = 4;
  localparam int PERIOD_MIN  = 1;
  localparam int NUM_PERIODS = 2;
  localparam int BUZZ_CYCLES = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       next_period = 1'b0;
  logic [7:0] ascii_1_min, ascii_0_min, ascii_1_sec, ascii_0_sec, ascii_0_period;
  logic       running, period_end, game_over, buzzer;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  game_clock_ascii #(
    .TICK_DIV(TICK_DIV), .PERIOD_MIN(PERIOD_MIN),
    .NUM_PERIODS(NUM_PERIODS), .BUZZ_CYCLES(BUZZ_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .next_period(next_period),
    .ascii_1_min(ascii_1_min), .ascii_0_min(ascii_0_min),
    .ascii_1_sec(ascii_1_sec), .ascii_0_sec(ascii_0_sec),
    .ascii_0_period(ascii_0_period), .running(running),
    .period_end(period_end), .game_over(game_over), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- model: time kept as whole seconds remaining ----------
  // phase: 0 idle, 1 run, 2 pause, 3 expired, 4 game over
  int m_secs = PERIOD_MIN * 60;
  int m_period = 1;
  int m_phase = 0;
  int m_frac = 0;        // RUN edges counted in the current second
  bit m_pend = 1'b0;
  int m_buzz = 0;        // horn cycles still to show

  always @(posedge clk) begin
    if (rst) begin
      m_secs = PERIOD_MIN * 60; m_period = 1; m_phase = 0;
      m_frac = 0; m_pend = 1'b0; m_buzz = 0;
    end else begin
      m_pend = 1'b0;
      if (m_buzz > 0) m_buzz--;
      case (m_phase)
        0: if (start_stop) m_phase = 1;
        1: begin
          m_frac++;
          if (m_frac == TICK_DIV) begin
            m_frac = 0;
            m_secs--;
          end
          if (m_secs == 0) begin
            m_phase = 3; m_pend = 1'b1; m_buzz = BUZZ_CYCLES;
          end else if (start_stop) begin
            m_phase = 2;
          end
        end
        2: if (start_stop) m_phase = 1;
        3: if (next_period) begin
          if (m_period < NUM_PERIODS) begin
            m_period++; m_secs = PERIOD_MIN * 60; m_frac = 0; m_phase = 0;
          end else begin
            m_phase = 4;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process: every falling edge once reset has been released.
  always @(negedge clk) begin
    if (armed) begin
      chk("min_tens",  ascii_1_min,    8'h30 + (m_secs / 60) / 10);
      chk("min_ones",  ascii_0_min,    8'h30 + (m_secs / 60) % 10);
      chk("sec_tens",  ascii_1_sec,    8'h30 + (m_secs % 60) / 10);
      chk("sec_ones",  ascii_0_sec,    8'h30 + (m_secs % 60) % 10);
      chk("period",    ascii_0_period, 8'h30 + m_period);
      chk("running",   running,        int'(m_phase == 1));
      chk("game_over", game_over,      int'(m_phase == 4));
      chk("period_end", period_end,    int'(m_pend));
`ifdef GAME_CLOCK_BUZZER_EN
      chk("buzzer",    buzzer,         int'(m_buzz > 0));
`else
      chk("buzzer",    buzzer,         0);
`endif
    end
  end

  // ---------------- directed stimulus -----------------------------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_time(input string name, input string mmss);
    chk({name, "_m1"}, ascii_1_min, mmss[0]);
    chk({name, "_m0"}, ascii_0_min, mmss[1]);
    chk({name, "_s1"}, ascii_1_sec, mmss[3]);
    chk({name, "_s0"}, ascii_0_sec, mmss[4]);
  endtask

  function automatic bit shows(input string mmss);
    return ascii_1_min == mmss[0] && ascii_0_min == mmss[1] &&
           ascii_1_sec == mmss[3] && ascii_0_sec == mmss[4];
  endfunction

  task automatic wait_end(input string name, input int limit);
    int n = 0;
    while (!period_end && n < limit) begin step(); n++; end
    chk({name, "_timeout"}, int'(period_end), 1);
  endtask

  task automatic wait_time(input string name, input string mmss, input int limit);
    int n = 0;
    while (!shows(mmss) && n < limit) begin step(); n++; end
    chk({name, "_timeout"}, int'(shows(mmss)), 1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step();
    armed = 1'b1;
    // reset state
    chk_time("reset", "01:00");
    chk("reset_period", ascii_0_period, "1");
    chk("reset_running", running, 0);
    chk("reset_over", game_over, 0);

    // countdown
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("start_running", running, 1);
    step(3);
    chk_time("pre_first", "01:00");
    step();
    chk_time("first_dec", "00:59");
    step(40);
    chk_time("ten_more", "00:49");

    // pause two cycles after a decrement
    step();
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("paused", running, 0);
    step(20);
    chk_time("pause_hold", "00:49");
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("resumed", running, 1);
    step();
    chk_time("resume_1", "00:49");
    step();
    chk_time("resume_2", "00:48");

    // run to expiry
    wait_end("exp1", 300);
    chk_time("exp1", "00:00");
    chk("exp1_running", running, 0);
    step();
    chk("exp1_pulse_width", period_end, 0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("exp1_ss_ignored", running, 0);
    chk_time("exp1_hold", "00:00");

    // start_stop together with next_period in EXPIRED lands in IDLE
    start_stop = 1'b1; next_period = 1'b1; step();
    start_stop = 1'b0; next_period = 1'b0;
    chk("p2_period", ascii_0_period, "2");
    chk_time("p2_reload", "01:00");
    chk("p2_idle", running, 0);
    step(2);
    chk("p2_still_idle", running, 0);

    // period 2: start_stop coinciding with the expiring tick is dropped
    start_stop = 1'b1; step(); start_stop = 1'b0;
    wait_time("p2_last", "00:01", 300);
    step(3);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("exp2_pulse", period_end, 1);
    chk_time("exp2", "00:00");
    chk("exp2_running", running, 0);
    step();
    chk("exp2_after", running, 0);

    // last period: next_period ends the game, then everything is ignored
    next_period = 1'b1; step(); next_period = 1'b0;
    chk("game_over", game_over, 1);
    start_stop = 1'b1; next_period = 1'b1; step();
    start_stop = 1'b0; next_period = 1'b0;
    step(2);
    chk("over_hold", game_over, 1);
    chk("over_running", running, 0);
    chk("over_period", ascii_0_period, "2");

    // reset mid-run at 00:37
    rst = 1'b1; step(); rst = 1'b0;
    start_stop = 1'b1; step(); start_stop = 1'b0;
    wait_time("to_37", "00:37", 200);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_time("mid_rst", "01:00");
    chk("mid_rst_period", ascii_0_period, "1");
    chk("mid_rst_running", running, 0);
    start_stop = 1'b1; step(); start_stop = 1'b0;
    chk("restart_running", running, 1);
    step(3);
    chk_time("restart_pre", "01:00");
    step();
    chk_time("restart_dec", "00:59");

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
